// File: rtl/frame_dump_ctrl.sv
// Frame-buffer dump controller: streams WIDTH x HEIGHT 32-bit words MSB-first to the UART on a button press.
// Optional header (0xA5, 0x5A, dump_seq) enabled by defining FRAME_DUMP_HEADER_EN.
module frame_dump_ctrl #(
    parameter int unsigned WIDTH         = 40,
    parameter int unsigned HEIGHT        = 30,
    parameter int unsigned X_BITS        = 6,
    parameter int unsigned Y_BITS        = 5,
    parameter int unsigned HOLDOFF_BITS  = 13,
    parameter int unsigned DEBOUNCE_BITS = 14
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              trigger,
    output logic [X_BITS-1:0] read_x,
    output logic [Y_BITS-1:0] read_y,
    input  logic [31:0]       read_q,
    input  logic              uart_busy,
    output logic              uart_write,
    output logic [7:0]        uart_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_LATCH, S_SEND, S_NEXT, S_DONE
    } state_t;

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

    state_t                   state;
    logic                     trig_m, trig_s;
    logic [DEBOUNCE_BITS-1:0] deb;
    logic [HOLDOFF_BITS-1:0]  hold;
    logic [1:0]               z;
    logic [31:0]              word;
    logic [7:0]               byte_sel;
    logic                     can_send;
`ifdef FRAME_DUMP_HEADER_EN
    logic [1:0]               hdr_cnt;
    logic [7:0]               dump_seq;
    logic [7:0]               hdr_byte;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            deb <= '0;
        else if (trig_s)
            deb <= '0;
        else if (deb != '1)
            deb <= deb + DEBOUNCE_BITS'(1);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            hold <= '0;
        else if (uart_busy || uart_write)
            hold <= '0;
        else if (hold != '1)
            hold <= hold + HOLDOFF_BITS'(1);
    end

    // uart_write is included so back-to-back header bytes cannot fire before uart_busy rises
    assign can_send = (hold == '1) && !uart_busy && !uart_write;

    always_comb begin
        byte_sel = word[7:0];
        case (z)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
    end

`ifdef FRAME_DUMP_HEADER_EN
    always_comb begin
        hdr_byte = dump_seq;
        case (hdr_cnt)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            default: hdr_byte = dump_seq;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= S_IDLE;
            read_x     <= '0;
            read_y     <= '0;
            z          <= '0;
            word       <= '0;
            uart_write <= 1'b0;
            uart_data  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_cnt    <= '0;
            dump_seq   <= '0;
`endif
        end else begin
            uart_write <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig_s && deb == '1) begin
                        read_x <= '0;
                        read_y <= '0;
                        z      <= '0;
                        busy   <= 1'b1;
`ifdef FRAME_DUMP_HEADER_EN
                        hdr_cnt <= '0;
                        state   <= S_HDR;
`else
                        state   <= S_FETCH;
`endif
                    end
                end
`ifdef FRAME_DUMP_HEADER_EN
                S_HDR: begin
                    if (can_send) begin
                        uart_write <= 1'b1;
                        uart_data  <= hdr_byte;
                        if (hdr_cnt == 2'd2)
                            state <= S_FETCH;
                        else
                            hdr_cnt <= hdr_cnt + 2'd1;
                    end
                end
`endif
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    word  <= read_q;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (can_send) begin
                        uart_write <= 1'b1;
                        uart_data  <= byte_sel;
                        state      <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (z != 2'd3) begin
                        z     <= z + 2'd1;
                        state <= S_SEND;
                    end else begin
                        z <= '0;
                        if (read_x != X_LAST) begin
                            read_x <= read_x + X_BITS'(1);
                            state  <= S_FETCH;
                        end else if (read_y != Y_LAST) begin
                            read_x <= '0;
                            read_y <= read_y + Y_BITS'(1);
                            state  <= S_FETCH;
                        end else begin
                            // frame_done is raised here so it is visible during the DONE cycle
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy   <= 1'b0;
                    read_x <= '0;
                    read_y <= '0;
`ifdef FRAME_DUMP_HEADER_EN
                    dump_seq <= dump_seq + 8'd1;
`endif
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Directed bench for frame_dump_ctrl on a 2x2 buffer with a busy-holding UART model.
module tb_frame_dump_ctrl;
    localparam int W  = 2;
    localparam int H  = 2;
`ifdef FRAME_DUMP_HEADER_EN
    localparam int HDR_N = 3;
`else
    localparam int HDR_N = 0;
`endif
    localparam int EXP_N = W * H * 4 + HDR_N;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       trigger;
    logic [0:0] read_x;
    logic [0:0] read_y;
    logic [31:0] read_q = '0;
    logic       uart_busy;
    logic       uart_write;
    logic [7:0] uart_data;
    logic       busy;
    logic       frame_done;

    frame_dump_ctrl #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(1), .Y_BITS(1),
        .HOLDOFF_BITS(3), .DEBOUNCE_BITS(3)
    ) dut (
        .clk(clk), .areset_n(areset_n), .trigger(trigger),
        .read_x(read_x), .read_y(read_y), .read_q(read_q),
        .uart_busy(uart_busy), .uart_write(uart_write), .uart_data(uart_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // buffer word (x,y): bytes tagged 1..4 in the high nibble, y / x / C / D in the low nibble
    always @(posedge clk)
        read_q <= {4'h1, 3'b000, read_y, 4'h2, 3'b000, read_x, 8'h3C, 8'h4D};

    int busy_cnt = 0;
    always @(posedge clk) begin
        if (uart_write) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy = (busy_cnt != 0);

    typedef struct {
        int         x;
        int         y;
        int         z;
        logic [7:0] exp_byte;
    } vec_t;
    vec_t tbl[EXP_N];

    int passed = 0;
    int total  = 0;
    int exp_seq = 0;

    logic [7:0] got_q[$];
    int cyc = 0, last_wr = -1, min_gap = 1000000;
    int stab_err = 0, dbl_err = 0, done_cnt = 0, busy_rises = 0;
    logic prev_wr = 1'b0, prev_busy = 1'b0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!areset_n) begin
            last_wr   = -1;
            prev_wr   = 1'b0;
            prev_busy = 1'b0;
            last_data = uart_data;
        end else begin
            if (uart_write) begin
                got_q.push_back(uart_data);
                if (last_wr >= 0 && cyc - last_wr < min_gap) min_gap = cyc - last_wr;
                if (prev_wr) dbl_err++;
                last_wr   = cyc;
                last_data = uart_data;
            end else if (last_wr >= 0 && uart_data !== last_data) begin
                stab_err++;
            end
            if (frame_done) done_cnt++;
            if (busy && !prev_busy) busy_rises++;
            prev_wr   = uart_write;
            prev_busy = busy;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_ge(input string name, input int act, input int lo);
        total++;
        if (act >= lo) passed++;
        else $display("FAIL %s: got %0d, expected >= %0d", name, act, lo);
    endtask

    task automatic build_tbl(input int seq);
        int i;
        i = 0;
        if (HDR_N != 0) begin
            tbl[0] = '{-1, -1, -1, 8'hA5};
            tbl[1] = '{-1, -1, -1, 8'h5A};
            tbl[2] = '{-1, -1, -1, 8'(seq)};
            i = 3;
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int z = 0; z < 4; z++) begin
                    tbl[i].x = x;
                    tbl[i].y = y;
                    tbl[i].z = z;
                    case (z)
                        0:       tbl[i].exp_byte = {4'h1, 4'(y)};
                        1:       tbl[i].exp_byte = {4'h2, 4'(x)};
                        2:       tbl[i].exp_byte = 8'h3C;
                        default: tbl[i].exp_byte = 8'h4D;
                    endcase
                    i++;
                end
    endtask

    task automatic clear_capture();
        got_q.delete();
        min_gap  = 1000000;
        stab_err = 0;
        dbl_err  = 0;
    endtask

    task automatic check_stream(input string name, input int seq);
        int act;
        build_tbl(seq);
        check($sformatf("%s byte count", name), got_q.size(), EXP_N);
        for (int i = 0; i < EXP_N; i++) begin
            act = (i < got_q.size()) ? int'(got_q[i]) : 'hFFFF;
            check($sformatf("%s byte %0d (x%0d y%0d z%0d)", name, i, tbl[i].x, tbl[i].y, tbl[i].z),
                  act, int'(tbl[i].exp_byte));
        end
        check_ge($sformatf("%s min write gap", name), min_gap, 17);
        check($sformatf("%s uart_data unstable", name), stab_err, 0);
        check($sformatf("%s back-to-back write", name), dbl_err, 0);
    endtask

    task automatic press(input int cycles);
        @(negedge clk);
        trigger = 1'b1;
        repeat (cycles) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n, d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s frame_done seen", name), int'(done_cnt != d0), 1);
    endtask

    task automatic wait_bytes(input string name, input int cnt);
        int n;
        n = 0;
        while (got_q.size() < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_ge($sformatf("%s bytes reached", name), got_q.size(), cnt);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " read_x"},     int'(read_x), 0);
        check({name, " read_y"},     int'(read_y), 0);
        check({name, " uart_write"}, int'(uart_write), 0);
        check({name, " uart_data"},  int'(uart_data), 0);
        check({name, " busy"},       int'(busy), 0);
        check({name, " frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, n0, n;
        areset_n = 1'b0;
        trigger  = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        areset_n = 1'b1;
        repeat (12) @(negedge clk);

        // basic dump
        clear_capture();
        d0 = done_cnt; r0 = busy_rises;
        press(3);
        wait_done("basic");
        repeat (5) @(negedge clk);
        check_stream("basic", exp_seq);
        check("basic frame_done pulses", done_cnt - d0, 1);
        check("basic busy after", int'(busy), 0);
        check("basic dumps started", busy_rises - r0, 1);
        exp_seq++;

        // second dump (header sequence number advances)
        clear_capture();
        press(3);
        wait_done("second");
        repeat (5) @(negedge clk);
        check_stream("second", exp_seq);
        exp_seq++;

        // held button across a whole dump
        clear_capture();
        r0 = busy_rises;
        @(negedge clk);
        trigger = 1'b1;
        wait_done("held");
        repeat (40) @(negedge clk);
        check_stream("held", exp_seq);
        check("held busy after", int'(busy), 0);
        check("held single dump", busy_rises - r0, 1);
        exp_seq++;

        // release too short to re-arm
        trigger = 1'b0;
        repeat (6) @(negedge clk);
        trigger = 1'b1;
        repeat (20) @(negedge clk);
        check("short release no dump", busy_rises - r0, 1);
        check("short release no bytes", got_q.size(), EXP_N);

        // release long enough to re-arm
        clear_capture();
        trigger = 1'b0;
        repeat (10) @(negedge clk);
        trigger = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("long release dump starts", int'(busy), 1);
        repeat (5) @(negedge clk);
        trigger = 1'b0;
        wait_done("rearm");
        repeat (5) @(negedge clk);
        check_stream("rearm", exp_seq);
        exp_seq++;

        // trigger pulse while a dump is running
        clear_capture();
        repeat (12) @(negedge clk);
        d0 = done_cnt; r0 = busy_rises;
        press(3);
        wait_bytes("midtrig", 5);
        press(3);
        wait_done("midtrig");
        repeat (30) @(negedge clk);
        check_stream("midtrig", exp_seq);
        check("midtrig frame_done pulses", done_cnt - d0, 1);
        check("midtrig dumps started", busy_rises - r0, 1);
        exp_seq++;

        // reset in the middle of a dump, button held through and after reset
        clear_capture();
        repeat (12) @(negedge clk);
        press(3);
        wait_bytes("abort", 7);
        trigger = 1'b1;
        @(negedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        check_outputs_zero("abort async");
        n0 = got_q.size();
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        exp_seq = 0;
        r0 = busy_rises;
        repeat (60) @(negedge clk);
        check("abort no bytes after release", got_q.size(), n0);
        check("abort busy stays low", int'(busy), 0);
        check("abort no new dump", busy_rises - r0, 0);
        trigger = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
